// File: rtl/rtc_bus_sched.sv
// RTC bus scheduler: runs refresh bursts of nine BCD register reads, commits them atomically
// as 18 display digits, and slots user writes in at transaction boundaries.
module rtc_bus_sched #(
  parameter int unsigned PHASE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  input  logic [7:0] bus_ad_in,
  output logic [7:0] bus_ad_out,
  output logic       bus_ad_oe,
  output logic       bus_ale,
  output logic       bus_cs_n,
  output logic       bus_rd_n,
  output logic       bus_wr_n,
  output logic       busy,
  output logic       frame_done,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dig4,
  output logic [3:0] dig5,
  output logic [3:0] dig6,
  output logic [3:0] dig7,
  output logic [3:0] dig8,
  output logic [3:0] dig9,
  output logic [3:0] dig10,
  output logic [3:0] dig11,
  output logic [3:0] dig12,
  output logic [3:0] dig13,
  output logic [3:0] dig14,
  output logic [3:0] dig15,
  output logic [3:0] dig16,
  output logic [3:0] dig17
);

  localparam int unsigned CntW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PHASE_CYC - 1);
  localparam logic [3:0] LastIdx = 4'd8;

  typedef enum logic [1:0] {StIdle, StAddr, StStrobe, StRecov} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            is_wr_q;
  logic [7:0]      addr_q;
  logic [7:0]      data_q;
  logic [3:0]      idx_q;
  logic            burst_q;
  logic            pend_q;
  logic            wr_ack_q;
  logic            frame_done_q;
  logic [7:0]      shadow_q [9];
  logic [7:0]      frame_q [9];

  logic phase_last;
  logic wr_grant;
  logic rd_go;

  function automatic logic [7:0] rd_addr(input logic [3:0] idx);
    logic [7:0] a;
    case (idx)
      4'd0:    a = 8'h24;
      4'd1:    a = 8'h25;
      4'd2:    a = 8'h26;
      4'd3:    a = 8'h23;
      4'd4:    a = 8'h22;
      4'd5:    a = 8'h21;
      4'd6:    a = 8'h43;
      4'd7:    a = 8'h42;
      4'd8:    a = 8'h41;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  assign phase_last = (cnt_q == CntLast);
  // The requester still holds wr_req during the ack cycle; it must not re-grant.
  assign wr_grant   = wr_req && !wr_ack_q;
  assign rd_go      = burst_q || pend_q || tick;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (wr_grant || rd_go) begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (phase_last) begin
          cnt_d   = '0;
          state_d = StStrobe;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStrobe: begin
        if (phase_last) begin
          cnt_d   = '0;
          state_d = StRecov;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRecov: begin
        if (phase_last) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_wr_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      idx_q        <= '0;
      burst_q      <= 1'b0;
      pend_q       <= 1'b0;
      wr_ack_q     <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        shadow_q[i] <= '0;
        frame_q[i]  <= '0;
      end
    end else begin
      wr_ack_q     <= 1'b0;
      frame_done_q <= 1'b0;

      if (state_q == StIdle) begin
        if (wr_grant) begin
          is_wr_q <= 1'b1;
          addr_q  <= wr_addr;
          data_q  <= wr_data;
          if (tick) begin
            pend_q <= 1'b1;
          end
        end else if (rd_go) begin
          is_wr_q <= 1'b0;
          if (burst_q) begin
            addr_q <= rd_addr(idx_q);
            if (tick) begin
              pend_q <= 1'b1;
            end
          end else begin
            // New burst; any tick seen now is absorbed by it.
            addr_q  <= rd_addr(4'd0);
            idx_q   <= '0;
            burst_q <= 1'b1;
            pend_q  <= 1'b0;
          end
        end
      end else if (tick) begin
        pend_q <= 1'b1;
      end

      if (state_q == StStrobe && phase_last && !is_wr_q) begin
        shadow_q[idx_q] <= bus_ad_in;
      end

      if (state_q == StRecov && phase_last) begin
        if (is_wr_q) begin
          wr_ack_q <= 1'b1;
        end else if (idx_q == LastIdx) begin
          frame_q      <= shadow_q;
          frame_done_q <= 1'b1;
          burst_q      <= 1'b0;
          idx_q        <= '0;
        end else begin
          idx_q <= idx_q + 4'd1;
        end
      end
    end
  end

  // Bus pins decode straight from state so reset idles them without waiting for a clock.
  always_comb begin
    bus_ale    = 1'b0;
    bus_cs_n   = 1'b1;
    bus_rd_n   = 1'b1;
    bus_wr_n   = 1'b1;
    bus_ad_oe  = 1'b0;
    bus_ad_out = '0;
    case (state_q)
      StAddr: begin
        bus_ale    = 1'b1;
        bus_cs_n   = 1'b0;
        bus_ad_oe  = 1'b1;
        bus_ad_out = addr_q;
      end
      StStrobe: begin
        bus_cs_n = 1'b0;
        if (is_wr_q) begin
          bus_wr_n   = 1'b0;
          bus_ad_oe  = 1'b1;
          bus_ad_out = data_q;
        end else begin
          bus_rd_n = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign wr_ack     = wr_ack_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != StIdle);

  assign dig0  = frame_q[0][7:4];
  assign dig1  = frame_q[0][3:0];
  assign dig2  = frame_q[1][7:4];
  assign dig3  = frame_q[1][3:0];
  assign dig4  = frame_q[2][7:4];
  assign dig5  = frame_q[2][3:0];
  assign dig6  = frame_q[3][7:4];
  assign dig7  = frame_q[3][3:0];
  assign dig8  = frame_q[4][7:4];
  assign dig9  = frame_q[4][3:0];
  assign dig10 = frame_q[5][7:4];
  assign dig11 = frame_q[5][3:0];
  assign dig12 = frame_q[6][7:4];
  assign dig13 = frame_q[6][3:0];
  assign dig14 = frame_q[7][7:4];
  assign dig15 = frame_q[7][3:0];
  assign dig16 = frame_q[8][7:4];
  assign dig17 = frame_q[8][3:0];

endmodule

// File: tb/tb_rtc_bus_sched.sv
// Scoreboard bench for rtc_bus_sched: an RTC bus model answers reads, a monitor checks every
// bus transaction and committed frame against queued expectations, tasks check timing.
module tb_rtc_bus_sched;

  localparam int P = 4;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic [7:0] bus_ad_in;
  logic [7:0] bus_ad_out;
  logic       bus_ad_oe;
  logic       bus_ale;
  logic       bus_cs_n;
  logic       bus_rd_n;
  logic       bus_wr_n;
  logic       busy;
  logic       frame_done;
  logic [3:0] d0, d1, d2, d3, d4, d5, d6, d7, d8;
  logic [3:0] d9, d10, d11, d12, d13, d14, d15, d16, d17;
  logic [71:0] digs;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0]  mem [256];
  logic [7:0]  lat;
  logic [7:0]  rd_tbl [9];
  logic [16:0] exp_txn [$];
  logic [71:0] exp_frame [$];

  rtc_bus_sched #(.PHASE_CYC(P)) dut (
    .clk(clk), .reset(reset), .tick(tick), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .bus_ad_in(bus_ad_in), .bus_ad_out(bus_ad_out),
    .bus_ad_oe(bus_ad_oe), .bus_ale(bus_ale), .bus_cs_n(bus_cs_n), .bus_rd_n(bus_rd_n),
    .bus_wr_n(bus_wr_n), .busy(busy), .frame_done(frame_done),
    .dig0(d0), .dig1(d1), .dig2(d2), .dig3(d3), .dig4(d4), .dig5(d5), .dig6(d6),
    .dig7(d7), .dig8(d8), .dig9(d9), .dig10(d10), .dig11(d11), .dig12(d12),
    .dig13(d13), .dig14(d14), .dig15(d15), .dig16(d16), .dig17(d17)
  );

  assign digs = {d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, d10, d11, d12, d13, d14, d15, d16, d17};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // RTC model: latch the address during ALE, return the addressed byte.
  always @(negedge clk) if (bus_ale) lat <= bus_ad_out;
  always_comb bus_ad_in = mem[lat];

  // Monitor: each completed strobe is popped against exp_txn, each commit against exp_frame.
  initial begin : monitor
    int          ale_cnt;
    int          st_cnt;
    logic        m_wr;
    logic [7:0]  m_addr;
    logic [7:0]  m_data;
    logic [16:0] e;
    logic [71:0] ef;
    ale_cnt = 0;
    st_cnt  = 0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ale_cnt = 0;
        st_cnt  = 0;
      end else begin
        if (bus_ale) begin
          ale_cnt++;
          m_addr = bus_ad_out;
        end
        if (!bus_rd_n || !bus_wr_n) begin
          st_cnt++;
          m_wr   = !bus_wr_n;
          m_data = !bus_wr_n ? bus_ad_out : bus_ad_in;
        end else if (st_cnt != 0) begin
          tests++;
          if (exp_txn.size() == 0) begin
            fails++;
            $display("FAIL txn_unexpected: got wr=%0b addr=%h data=%h, none expected",
                     m_wr, m_addr, m_data);
          end else begin
            e = exp_txn.pop_front();
            if ({m_wr, m_addr, m_data} !== e || ale_cnt != P || st_cnt != P) begin
              fails++;
              $display("FAIL txn: got wr=%0b addr=%h data=%h ale=%0d strobe=%0d, need %h w=%0d",
                       m_wr, m_addr, m_data, ale_cnt, st_cnt, e, P);
            end
          end
          ale_cnt = 0;
          st_cnt  = 0;
        end
        if (frame_done) begin
          tests++;
          if (exp_frame.size() == 0) begin
            fails++;
            $display("FAIL frame_unexpected: got digits %h", digs);
          end else begin
            ef = exp_frame.pop_front();
            if (digs !== ef) begin
              fails++;
              $display("FAIL frame: got digits %h, need %h", digs, ef);
            end
          end
        end
      end
    end
  end

  task automatic push_reads(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_txn.push_back({1'b0, rd_tbl[i], mem[rd_tbl[i]]});
  endtask

  task automatic push_frame();
    logic [71:0] f;
    f = '0;
    for (int i = 0; i < 9; i++) f = {f[63:0], mem[rd_tbl[i]]};
    exp_frame.push_back(f);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus_cs_n, bus_rd_n, bus_wr_n, bus_ale, bus_ad_oe} !== 5'b11100 || bus_ad_out !== 8'h00)
    begin
      fails++;
      $display("FAIL reset_bus: got cs/rd/wr/ale/oe=%b out=%h, need 11100 out=00",
               {bus_cs_n, bus_rd_n, bus_wr_n, bus_ale, bus_ad_oe}, bus_ad_out);
    end
    tests++;
    if ({wr_ack, frame_done, busy} !== 3'b000 || digs !== 72'h0) begin
      fails++;
      $display("FAIL reset_status: got ack/fd/busy=%b digits=%h, need 000 and zero digits",
               {wr_ack, frame_done, busy}, digs);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_idle_refresh();
    int t0;
    int fd;
    fd = -1;
    push_reads(0, 8);
    push_frame();
    tick = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      tick = 1'b0;
      if (cyc - t0 == 1) begin
        tests++;
        if ({busy, bus_ale, bus_cs_n, bus_ad_oe} !== 4'b1101 || bus_ad_out !== 8'h24) begin
          fails++;
          $display("FAIL first_addr: got busy/ale/cs_n/oe=%b out=%h, need 1101 out=24",
                   {busy, bus_ale, bus_cs_n, bus_ad_oe}, bus_ad_out);
        end
      end
      if (frame_done) begin
        fd = cyc - t0;
        break;
      end
    end
    tests++;
    if (fd != 117) begin
      fails++;
      $display("FAIL refresh_latency: got frame_done at cycle %0d, need 117", fd);
    end
    tests++;
    if (digs !== 72'h150616094530010203) begin
      fails++;
      $display("FAIL refresh_digits: got %h, need 150616094530010203", digs);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write_alone();
    int t0;
    int ack;
    logic [71:0] saved;
    ack   = -1;
    saved = digs;
    exp_txn.push_back({1'b1, 8'h22, 8'h59});
    wr_addr = 8'h22;
    wr_data = 8'h59;
    wr_req  = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wr_ack) begin
        ack = cyc - t0;
        wr_req = 1'b0;
        break;
      end
    end
    if (ack < 0) wr_req = 1'b0;
    tests++;
    if (ack != 13) begin
      fails++;
      $display("FAIL write_latency: got wr_ack at cycle %0d, need 13", ack);
    end
    @(negedge clk);
    tests++;
    if (wr_ack !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL write_handoff: got wr_ack=%b busy=%b after ack, need 0 0", wr_ack, busy);
    end
    tests++;
    if (digs !== saved) begin
      fails++;
      $display("FAIL write_digits: got %h, need unchanged %h", digs, saved);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write_mid_burst();
    int t0;
    int ack;
    int fd;
    logic [71:0] old;
    ack = -1;
    fd  = -1;
    old = digs;
    mem[8'h24] = 8'h28; mem[8'h25] = 8'h02; mem[8'h26] = 8'h24;
    mem[8'h23] = 8'h23; mem[8'h22] = 8'h59; mem[8'h21] = 8'h58;
    mem[8'h43] = 8'h12; mem[8'h42] = 8'h34; mem[8'h41] = 8'h56;
    push_reads(0, 3);
    exp_txn.push_back({1'b1, 8'h10, 8'hA5});
    push_reads(4, 8);
    push_frame();
    wr_addr = 8'h10;
    wr_data = 8'hA5;
    tick = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      tick = 1'b0;
      if (cyc - t0 == 45) wr_req = 1'b1;
      if (wr_ack) begin
        ack = cyc - t0;
        wr_req = 1'b0;
      end
      if (cyc - t0 == 100) begin
        tests++;
        if (digs !== old) begin
          fails++;
          $display("FAIL partial_visible: got %h mid-burst, need %h", digs, old);
        end
      end
      if (frame_done) begin
        fd = cyc - t0;
        break;
      end
    end
    wr_req = 1'b0;
    tests++;
    if (ack != 65 || fd != 130) begin
      fails++;
      $display("FAIL mid_burst_timing: got ack=%0d frame_done=%0d, need 65 130", ack, fd);
    end
    tests++;
    if (digs !== 72'h280224235958123456) begin
      fails++;
      $display("FAIL mid_burst_digits: got %h, need 280224235958123456", digs);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_tick_coalesce();
    int t0;
    int n;
    int k;
    int last;
    n    = 0;
    last = -1;
    push_reads(0, 8);
    push_frame();
    tick = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 320; i++) begin
      @(negedge clk);
      k = cyc - t0;
      tick = (k == 20 || k == 40 || k == 60);
      if (k == 20) begin
        push_reads(0, 8);
        push_frame();
      end
      if (frame_done) begin
        n++;
        last = k;
      end
    end
    tick = 1'b0;
    tests++;
    if (n != 2 || last != 234) begin
      fails++;
      $display("FAIL coalesce: got %0d frame_done pulses, last at %0d, need 2 at 234", n, last);
    end
    tests++;
    if (exp_txn.size() != 0 || exp_frame.size() != 0) begin
      fails++;
      $display("FAIL coalesce_drain: got %0d txns and %0d frames outstanding, need 0 0",
               exp_txn.size(), exp_frame.size());
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    int fd;
    fd = -1;
    push_reads(0, 8);
    push_frame();
    tick = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      tick = 1'b0;
      if (cyc - t0 == 71) break;
    end
    tests++;
    if (bus_rd_n !== 1'b0 || lat !== 8'h21) begin
      fails++;
      $display("FAIL pre_reset_strobe: got rd_n=%b addr=%h, need 0 21", bus_rd_n, lat);
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if ({bus_cs_n, bus_rd_n, bus_ale, bus_ad_oe} !== 4'b1100) begin
      fails++;
      $display("FAIL reset_async: got cs_n/rd_n/ale/oe=%b, need 1100",
               {bus_cs_n, bus_rd_n, bus_ale, bus_ad_oe});
    end
    @(negedge clk);
    tests++;
    if ({bus_cs_n, bus_rd_n, bus_wr_n, bus_ale, bus_ad_oe, wr_ack, frame_done, busy}
        !== 8'b11100000 || bus_ad_out !== 8'h00 || digs !== 72'h0) begin
      fails++;
      $display("FAIL reset_mid_values: got pins=%b out=%h digits=%h, need 11100000 00 zero",
               {bus_cs_n, bus_rd_n, bus_wr_n, bus_ale, bus_ad_oe, wr_ack, frame_done, busy},
               bus_ad_out, digs);
    end
    exp_txn.delete();
    exp_frame.delete();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    push_reads(0, 8);
    push_frame();
    tick = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      tick = 1'b0;
      if (frame_done) begin
        fd = cyc - t0;
        break;
      end
    end
    tests++;
    if (fd != 117 || digs !== 72'h280224235958123456) begin
      fails++;
      $display("FAIL post_reset_burst: got frame_done=%0d digits=%h, need 117 280224235958123456",
               fd, digs);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int t0;
    int ack;
    int ale;
    int fd;
    ack = -1;
    ale = -1;
    fd  = -1;
    exp_txn.push_back({1'b1, 8'h30, 8'h11});
    push_reads(0, 8);
    push_frame();
    wr_addr = 8'h30;
    wr_data = 8'h11;
    wr_req  = 1'b1;
    tick    = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      tick = 1'b0;
      if (wr_ack) begin
        ack = cyc - t0;
        wr_req = 1'b0;
      end
      if (bus_ale && ack >= 0 && ale < 0) ale = cyc - t0;
      if (frame_done) begin
        fd = cyc - t0;
        break;
      end
    end
    wr_req = 1'b0;
    tests++;
    if (ack != 13 || ale != 14 || fd != 130) begin
      fails++;
      $display("FAIL simultaneous: got ack=%0d first_ale=%0d frame_done=%0d, need 13 14 130",
               ack, ale, fd);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (exp_txn.size() != 0 || exp_frame.size() != 0) begin
      fails++;
      $display("FAIL final_drain: got %0d txns and %0d frames outstanding, need 0 0",
               exp_txn.size(), exp_frame.size());
    end
  endtask

  initial begin
    reset   = 1'b1;
    tick    = 1'b0;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rd_tbl[0] = 8'h24; rd_tbl[1] = 8'h25; rd_tbl[2] = 8'h26;
    rd_tbl[3] = 8'h23; rd_tbl[4] = 8'h22; rd_tbl[5] = 8'h21;
    rd_tbl[6] = 8'h43; rd_tbl[7] = 8'h42; rd_tbl[8] = 8'h41;
    mem[8'h24] = 8'h15; mem[8'h25] = 8'h06; mem[8'h26] = 8'h16;
    mem[8'h23] = 8'h09; mem[8'h22] = 8'h45; mem[8'h21] = 8'h30;
    mem[8'h43] = 8'h01; mem[8'h42] = 8'h02; mem[8'h41] = 8'h03;

    test_reset();
    test_idle_refresh();
    test_write_alone();
    test_write_mid_burst();
    test_tick_coalesce();
    test_reset_mid();
    test_simultaneous();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rtc_bus_sched.md
# rtc_bus_sched

- Scheduler for the shared parallel RTC bus (multiplexed address/data, ALE-latched).
- On each refresh tick it runs a burst of nine BCD register reads and commits them atomically as the 18 display digits `dig0`..`dig17` consumed by the text generator.
- It interleaves user configuration writes at transaction boundaries, giving writes priority over refresh reads.
- Sits between the RTC pin interface and the VGA text path.

## Interface
- `PHASE_CYC`, default 4: clock cycles per bus phase, minimum 1.
- `clk`  in  1: system clock; all logic on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `tick`  in  1: one-cycle refresh request pulse.
- `wr_req`  in  1: write request, level; held until `wr_ack`.
- `wr_addr`  in  8: RTC register address; sampled at grant.
- `wr_data`  in  8: write data; sampled at grant.
- `wr_ack`  out  1: one-cycle pulse; write transaction completed.
- `bus_ad_in`  in  8: AD bus read data.
- `bus_ad_out`  out  8: AD bus drive value.
- `bus_ad_oe`  out  1: AD output enable; drive `bus_ad_out` when 1.
- `bus_ale`  out  1: address latch enable, active high.
- `bus_cs_n`, `bus_rd_n`, `bus_wr_n`  out  1 each: chip select, read strobe, write strobe; all active low.
- `busy`  out  1: FSM is not in IDLE.
- `frame_done`  out  1: one-cycle pulse; the cycle in which newly committed digits first appear.
- `dig0`..`dig17`  out  4 each: committed BCD digits.

## Operation
- FSM states: IDLE, ADDR, STROBE, RECOV. ADDR, STROBE and RECOV each last `PHASE_CYC` cycles, timed by a phase counter.
- **IDLE decision**, in priority order:
  - `wr_req` high: grant a write. Latch `wr_addr`/`wr_data`, then go to ADDR.
  - Otherwise, if a burst is active, or `refresh_pending`, or `tick` is high: read register index `idx`, then go to ADDR. Starting a new burst sets `idx`=0 and clears `refresh_pending`.
  - Otherwise stay in IDLE.
- **ADDR phase:** `bus_ale`=1, `bus_cs_n`=0, `bus_ad_oe`=1, `bus_ad_out`=address.
- **STROBE phase:** `bus_cs_n`=0, `bus_ale`=0.
  - Read: `bus_rd_n`=0, `bus_ad_oe`=0. `bus_ad_in` is captured into `shadow[idx]` on the edge ending the last STROBE cycle.
  - Write: `bus_wr_n`=0, `bus_ad_oe`=1, `bus_ad_out`=`wr_data`.
- **RECOV phase:** all strobes inactive, `bus_ad_oe`=0, `bus_ad_out`=0.
  - On the edge ending the last RECOV cycle: write → `wr_ack`=1 next cycle; read → `idx`++.
  - If `idx` was 8: commit all shadow bytes to the digits, `frame_done`=1 next cycle, burst ends.
- **Read address table**, index 0..8: 0x24 day, 0x25 month, 0x26 year, 0x23 hour, 0x22 min, 0x21 sec, 0x43 timer hr, 0x42 timer min, 0x41 timer sec.
- **Digit mapping:** byte `k` → `dig(2k)`=[7:4], `dig(2k+1)`=[3:0]. So `dig0`/`dig1` = day … `dig16`/`dig17` = timer sec.
- Nibbles pass through raw; no BCD validation.
- **Writes:** a write may be granted between reads of an active burst. The burst then resumes at the same `idx`; the shadow is untouched.
- **Ticks:**
  - A tick arriving when the FSM is not in IDLE, or while a burst is active, sets `refresh_pending`.
  - Further ticks while `refresh_pending` is set are coalesced (dropped).
  - A pending refresh starts a new burst after the current burst commits, unless a write is requested.

## Timing
- **Reset values:** `bus_cs_n`/`bus_rd_n`/`bus_wr_n`=1; `bus_ale`/`bus_ad_oe`=0; `bus_ad_out`=0; `wr_ack`/`frame_done`/`busy`=0; all digits 0; shadow 0; `idx`=0; `refresh_pending`=0; FSM in IDLE.
- **Transaction length:** `3*PHASE_CYC` cycles plus 1 IDLE decision cycle.
- **Burst length**, no writes interleaved: `9*(3*PHASE_CYC+1)` cycles. With `PHASE_CYC`=4 and `tick` in IDLE at cycle 0:
  - First ADDR occupies cycles 1–4.
  - Last RECOV ends at cycle 116.
  - Digits update and `frame_done`=1 at cycle 117.
- **Write latency:** `wr_req` high in IDLE at cycle 0 → `wr_ack` at cycle `3*PHASE_CYC+1`.
- **Write hand-off:** `wr_req` must drop the cycle after `wr_ack`. If it is still high on the next IDLE cycle, that is a new write.
- **Simultaneous `wr_req` and `tick` in IDLE:** write goes first, the tick sets `refresh_pending`, and the burst starts at the next IDLE.
- **Reset mid-transaction:** the bus returns to idle levels immediately. The shadow is discarded, digits clear, and no `wr_ack` is issued.
- Digits never change except on a commit; partial bursts are never visible.

## Test plan
- **Idle refresh:** reset, then `tick` at cycle 0. The bus model returns 0x15,0x06,0x16,0x09,0x45,0x30,0x01,0x02,0x03 for addresses 0x24,0x25,0x26,0x23,0x22,0x21,0x43,0x42,0x41.
  - Required: `frame_done` at cycle 117.
  - Required: `dig0..dig17` = 1,5,0,6,1,6,0,9,4,5,3,0,0,1,0,2,0,3.
  - Required: ALE/RD phase widths of 4 cycles.
- **Write alone:** `wr_req` with addr 0x22, data 0x59.
  - Required: ADDR drives 0x22; STROBE drives 0x59 with `bus_wr_n`=0 for 4 cycles.
  - Required: `wr_ack` at cycle 13; digits unchanged.
- **Write mid-burst:** `wr_req` raised during read `idx`=3.
  - Required: the write executes after read 3's RECOV; read 4 follows.
  - Required: `frame_done` at cycle 130; digits are correct.
- **Tick coalescing:** three ticks during one burst.
  - Required: exactly one additional burst, so exactly two `frame_done` pulses total.
- **Reset during STROBE of read 5:**
  - Required: all outputs at reset values the next cycle.
  - Required: a later tick yields a full 9-read burst starting at 0x24.
- **Simultaneous `tick` and `wr_req` in IDLE:**
  - Required: write first (`wr_ack` at cycle 13), then the burst's first ADDR at cycle 14.
